// File: rtl/nibble_acc_pkg.sv
// Shared types and helpers for the nibble-serial accumulator.
package nibble_acc_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADD,
    ST_DONE
  } state_t;

  // Never returns less than 1, so a single-nibble accumulator still gets a real counter.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/nibble_add_slice.sv
// Combinational 4-bit add slice with carry in/out.
module nibble_add_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};

endmodule

// File: rtl/nibble_serial_accumulator.sv
// Serial unsigned accumulator: one nibble per clock through a single add slice.
// Optional macro SATURATE_EN clamps the result to all ones on carry-out instead of wrapping.
module nibble_serial_accumulator
  import nibble_acc_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 out_valid,
  output logic                 overflow,
  output logic                 busy
);

  localparam int N  = ACC_WIDTH / NIBBLE_W;
  localparam int CW = clog2(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

  if ((WIDTH % 4 != 0) || (ACC_WIDTH % 4 != 0) || (ACC_WIDTH < WIDTH)) begin : g_param_check
    $error("nibble_serial_accumulator: WIDTH and ACC_WIDTH must be multiples of 4 with ACC_WIDTH >= WIDTH");
  end

  state_t                 state;
  state_t                 state_nxt;
  logic [ACC_WIDTH-1:0]   acc;
  logic [ACC_WIDTH-1:0]   op;
  logic [ACC_WIDTH-1:0]   rotated;
  logic [CW-1:0]          cnt;
  logic                   carry;
  logic [NIBBLE_W-1:0]    sum;
  logic                   cout;
  logic                   last;

  nibble_add_slice u_slice (
    .a    (acc[NIBBLE_W-1:0]),
    .b    (op[NIBBLE_W-1:0]),
    .cin  (carry),
    .sum  (sum),
    .cout (cout)
  );

  // The new nibble enters at the top, so after N cycles acc is back in natural order.
  if (N == 1) begin : g_rot_single
    assign rotated = sum;
  end else begin : g_rot_multi
    assign rotated = {sum, acc[ACC_WIDTH-1:NIBBLE_W]};
  end

  assign last      = (cnt == LAST_CNT);
  assign in_ready  = (state == ST_IDLE) && !clear;
  assign busy      = (state != ST_IDLE);
  assign out_valid = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_valid && in_ready) state_nxt = ST_ADD;
      ST_ADD:  if (last) state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // acc_out is only written on the final add edge, so it never exposes a half-rotated acc.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc      <= '0;
      op       <= '0;
      cnt      <= '0;
      carry    <= 1'b0;
      acc_out  <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clear) begin
            acc      <= '0;
            acc_out  <= '0;
            overflow <= 1'b0;
          end else if (in_valid) begin
            op    <= ACC_WIDTH'(in_data);
            cnt   <= '0;
            carry <= 1'b0;
          end
        end
        ST_ADD: begin
          acc   <= rotated;
          op    <= op >> NIBBLE_W;
          carry <= cout;
          cnt   <= cnt + CW'(1);
          if (last) begin
            carry    <= 1'b0;
            overflow <= overflow | cout;
`ifdef SATURATE_EN
            if (cout) begin
              acc     <= '1;
              acc_out <= '1;
            end else begin
              acc_out <= rotated;
            end
`else
            acc_out <= rotated;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_accumulator.sv
// Randomized scoreboard bench for nibble_serial_accumulator (24-bit and 16-bit accumulator instances).
module tb_nibble_serial_accumulator;

  localparam int AW_A = 24;
  localparam int N_A  = 6;
  localparam int AW_B = 16;
  localparam int N_B  = 4;

  typedef struct {
    longint acc;
    bit     ovf;
    int     cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear_a, in_valid_a, in_ready_a, out_valid_a, overflow_a, busy_a;
  logic [15:0] in_data_a;
  logic [23:0] acc_out_a;
  logic        clear_b, in_valid_b, in_ready_b, out_valid_b, overflow_b, busy_b;
  logic [15:0] in_data_b;
  logic [15:0] acc_out_b;

  int     compared   = 0;
  int     mismatched = 0;
  int     cyc        = 0;
  exp_t   qa[$];
  exp_t   qb[$];
  longint m_acc[2];
  bit     m_ovf[2];
  bit     prev_ov[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  nibble_serial_accumulator #(.WIDTH(16), .ACC_WIDTH(AW_A)) dut_a (
    .clk(clk), .rst(rst), .clear(clear_a), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .acc_out(acc_out_a), .out_valid(out_valid_a),
    .overflow(overflow_a), .busy(busy_a)
  );

  nibble_serial_accumulator #(.WIDTH(16), .ACC_WIDTH(AW_B)) dut_b (
    .clk(clk), .rst(rst), .clear(clear_b), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .acc_out(acc_out_b), .out_valid(out_valid_b),
    .overflow(overflow_b), .busy(busy_b)
  );

  task automatic checkOutput(input string name, input longint act, input longint exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: plain unsigned addition with wrap or clamp at 2**aw.
  task automatic modelPush(input bit sel, input logic [15:0] d, input int tcyc);
    longint s;
    longint lim;
    exp_t   e;
    lim = longint'(1) << (sel ? AW_B : AW_A);
    s   = m_acc[sel] + longint'(d);
    if (s >= lim) begin
      m_ovf[sel] = 1'b1;
`ifdef SATURATE_EN
      s = lim - 1;
`else
      s = s - lim;
`endif
    end
    m_acc[sel] = s;
    e.acc = s;
    e.ovf = m_ovf[sel];
    e.cyc = tcyc + (sel ? N_B : N_A);
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
  endtask

  task automatic monitorStep(input bit sel, input logic ov, input longint acc, input logic ovf,
                             input logic rdy, input logic bsy);
    exp_t e;
    if (bsy) checkOutput(sel ? "b_ready_while_busy" : "a_ready_while_busy", rdy, 0);
    if (ov) begin
      checkOutput(sel ? "b_pulse_width" : "a_pulse_width", prev_ov[sel], 0);
      if ((sel ? qb.size() : qa.size()) == 0) begin
        checkOutput(sel ? "b_unexpected_out_valid" : "a_unexpected_out_valid", ov, 0);
      end else begin
        if (sel) e = qb.pop_front();
        else     e = qa.pop_front();
        checkOutput(sel ? "b_acc_out" : "a_acc_out", acc, e.acc);
        checkOutput(sel ? "b_overflow" : "a_overflow", ovf, e.ovf);
        checkOutput(sel ? "b_latency" : "a_latency", cyc, e.cyc);
      end
    end
    prev_ov[sel] = ov;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_ov[0] = 1'b0;
      prev_ov[1] = 1'b0;
    end else begin
      monitorStep(1'b0, out_valid_a, longint'(acc_out_a), overflow_a, in_ready_a, busy_a);
      monitorStep(1'b1, out_valid_b, longint'(acc_out_b), overflow_b, in_ready_b, busy_b);
    end
  end

  // Offers one operand and holds it until the handshake edge.
  task automatic applyStimulus(input bit sel, input logic [15:0] d);
    int waited;
    waited = 0;
    @(negedge clk);
    if (sel) begin in_valid_b = 1'b1; in_data_b = d; end
    else     begin in_valid_a = 1'b1; in_data_a = d; end
    #1;
    while (!(sel ? in_ready_b : in_ready_a) && waited < 50) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (sel) checkOutput("b_handshake_timeout", in_ready_b, 1);
    else     checkOutput("a_handshake_timeout", in_ready_a, 1);
    if (sel ? in_ready_b : in_ready_a) modelPush(sel, d, cyc + 1);
    @(negedge clk);
    if (sel) in_valid_b = 1'b0;
    else     in_valid_a = 1'b0;
  endtask

  task automatic waitIdle(input bit sel);
    int n;
    n = 0;
    while (((sel ? qb.size() : qa.size()) != 0 || (sel ? busy_b : busy_a)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput(sel ? "b_drain" : "a_drain", sel ? qb.size() : qa.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int caps;
    logic [15:0] d;
    rst = 1'b1;
    clear_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0;
    clear_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0;
    m_acc[0] = 0; m_acc[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
    repeat (3) @(negedge clk);
    checkOutput("reset_acc_out", acc_out_a, 0);
    checkOutput("reset_out_valid", out_valid_a, 0);
    checkOutput("reset_in_ready", in_ready_a, 1);
    checkOutput("reset_overflow", overflow_a, 0);
    checkOutput("reset_busy", busy_a, 0);
    rst = 1'b0;

    applyStimulus(1'b0, 16'h00FF);
    applyStimulus(1'b0, 16'h0001);
    waitIdle(1'b0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 16'($urandom));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    waitIdle(1'b0);

    applyStimulus(1'b1, 16'hFFFF);
    applyStimulus(1'b1, 16'h0002);
    waitIdle(1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 16'($urandom));
    waitIdle(1'b1);

    // Operand held for 20 cycles: the block should take one every 8 cycles.
    caps = 0;
    d = 16'($urandom);
    @(negedge clk);
    in_valid_a = 1'b1;
    in_data_a  = d;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (in_ready_a) begin
        modelPush(1'b0, d, cyc + 1);
        caps++;
      end
      @(negedge clk);
    end
    in_valid_a = 1'b0;
    checkOutput("held_valid_captures", caps, 3);
    waitIdle(1'b0);

    @(negedge clk);
    clear_a    = 1'b1;
    in_valid_a = 1'b1;
    in_data_a  = 16'($urandom);
    #1;
    checkOutput("clear_blocks_ready", in_ready_a, 0);
    @(negedge clk);
    clear_a    = 1'b0;
    in_valid_a = 1'b0;
    m_acc[0] = 0;
    m_ovf[0] = 0;
    checkOutput("clear_acc_out", acc_out_a, 0);
    checkOutput("clear_overflow", overflow_a, 0);
    checkOutput("clear_no_capture", busy_a, 0);

    // Enough all-ones operands to carry past bit 23 and exercise the 24-bit overflow path.
    for (int i = 0; i < 260; i++) applyStimulus(1'b0, 16'hFFFF);
    waitIdle(1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 16'($urandom));
    waitIdle(1'b0);

    applyStimulus(1'b0, 16'($urandom));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    qa.delete();
    qb.delete();
    m_acc[0] = 0; m_acc[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
    @(negedge clk);
    checkOutput("midadd_reset_acc_out", acc_out_a, 0);
    checkOutput("midadd_reset_out_valid", out_valid_a, 0);
    checkOutput("midadd_reset_in_ready", in_ready_a, 1);
    checkOutput("midadd_reset_overflow", overflow_a, 0);
    checkOutput("midadd_reset_busy", busy_a, 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);

    applyStimulus(1'b0, 16'h1234);
    applyStimulus(1'b0, 16'($urandom));
    waitIdle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
